// File: rtl/level_sequencer.sv
// Game sequencer: runs each level's timed generation phase, starts the post period,
// judges the player's count and drives the level/time seven-segment digits.
module level_sequencer #(
  parameter int PLAY_SECONDS = 20,
  parameter int NUM_LEVELS   = 9,
  parameter int START_LIVES  = 3,
  parameter int POST_TIMEOUT = 8
) (
  input  logic       Clk100M,
  input  logic       Rst_n,
  input  logic       tick1Hz,
  input  logic       startBtn,
  input  logic       levelComplete,
  input  logic [7:0] magicSymbolCount,
  input  logic [7:0] userCount,
  output logic       genEnable,
  output logic       clearCounts,
  output logic       postSig,
  output logic [3:0] level,
  output logic [2:0] lives,
  output logic       gameOver,
  output logic       gameWon,
  output logic [7:0] timeSeg0,
  output logic [7:0] timeSeg1,
  output logic [7:0] levelSeg,
  output logic [2:0] dbgState
);

  // Handshake: postSig and clearCounts are one-cycle strobes with no back-pressure;
  // levelComplete is a one-cycle strobe that is only accepted while in POST.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_POST  = 3'd2,
    S_JUDGE = 3'd3,
    S_WIN   = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam logic [6:0] L_PLAY    = 7'(PLAY_SECONDS);
  localparam logic [3:0] L_LEVELS  = 4'(NUM_LEVELS);
  localparam logic [2:0] L_LIVES   = 3'(START_LIVES);
  localparam logic [7:0] L_TIMEOUT = 8'(POST_TIMEOUT);

  state_t     r_state;
  logic [3:0] r_level;
  logic [2:0] r_lives;
  logic [6:0] r_remaining;
  logic [7:0] r_post_timer;
  logic       r_start_prev;
  logic       r_gen_enable;
  logic       r_clear_counts;
  logic       r_post_sig;
  logic       r_game_over;
  logic       r_game_won;
  logic [7:0] r_time_seg0;
  logic [7:0] r_time_seg1;
  logic [7:0] r_level_seg;

  logic       w_start_edge;
  logic       w_counts_match;
  logic [7:0] w_post_timer_inc;
  logic       w_timeout;
  logic [3:0] w_tens;
  logic [3:0] w_ones;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hD8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign w_start_edge     = startBtn & ~r_start_prev;
  assign w_counts_match   = (userCount == magicSymbolCount);
  assign w_post_timer_inc = r_post_timer + 8'd1;
  assign w_timeout        = tick1Hz && (w_post_timer_inc >= L_TIMEOUT);
  assign w_tens           = 4'(r_remaining / 7'd10);
  assign w_ones           = 4'(r_remaining % 7'd10);

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state        <= S_IDLE;
      r_level        <= 4'd1;
      r_lives        <= L_LIVES;
      r_remaining    <= 7'd0;
      r_post_timer   <= 8'd0;
      r_start_prev   <= 1'b0;
      r_gen_enable   <= 1'b0;
      r_clear_counts <= 1'b0;
      r_post_sig     <= 1'b0;
      r_game_over    <= 1'b0;
      r_game_won     <= 1'b0;
    end else begin
      r_start_prev   <= startBtn;
      r_clear_counts <= 1'b0;
      r_post_sig     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_state        <= S_PLAY;
            r_remaining    <= L_PLAY;
            r_clear_counts <= 1'b1;
            r_gen_enable   <= 1'b1;
          end
        end
        S_PLAY: begin
          if (tick1Hz) begin
            if (r_remaining <= 7'd1) begin
              r_remaining  <= 7'd0;
              r_state      <= S_POST;
              r_post_sig   <= 1'b1;
              r_gen_enable <= 1'b0;
              r_post_timer <= 8'd0;
            end else begin
              r_remaining <= r_remaining - 7'd1;
            end
          end
        end
        S_POST: begin
          if (tick1Hz) r_post_timer <= w_post_timer_inc;
          // A completion strobe and the timeout landing together still yield one judgement.
          if (levelComplete || w_timeout) r_state <= S_JUDGE;
        end
        S_JUDGE: begin
          if (w_counts_match) begin
            if (r_level >= L_LEVELS) begin
              r_state    <= S_WIN;
              r_game_won <= 1'b1;
            end else begin
              r_level        <= r_level + 4'd1;
              r_state        <= S_PLAY;
              r_remaining    <= L_PLAY;
              r_clear_counts <= 1'b1;
              r_gen_enable   <= 1'b1;
            end
          end else if (r_lives <= 3'd1) begin
            r_lives     <= 3'd0;
            r_state     <= S_OVER;
            r_game_over <= 1'b1;
          end else begin
            r_lives        <= r_lives - 3'd1;
            r_state        <= S_PLAY;
            r_remaining    <= L_PLAY;
            r_clear_counts <= 1'b1;
            r_gen_enable   <= 1'b1;
          end
        end
        S_WIN, S_OVER: begin
          if (w_start_edge) begin
            r_level        <= 4'd1;
            r_lives        <= L_LIVES;
            r_game_won     <= 1'b0;
            r_game_over    <= 1'b0;
            r_state        <= S_PLAY;
            r_remaining    <= L_PLAY;
            r_clear_counts <= 1'b1;
            r_gen_enable   <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Digits follow the registered state/count, so they trail a change by one cycle.
  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      r_time_seg0 <= 8'hFF;
      r_time_seg1 <= 8'hFF;
      r_level_seg <= 8'hFF;
    end else begin
      case (r_state)
        S_PLAY: begin
          r_time_seg0 <= seg7(w_tens);
          r_time_seg1 <= seg7(w_ones);
        end
        S_POST, S_JUDGE: begin
          r_time_seg0 <= 8'hC0;
          r_time_seg1 <= 8'hC0;
        end
        default: begin
          r_time_seg0 <= 8'hFF;
          r_time_seg1 <= 8'hFF;
        end
      endcase
      r_level_seg <= (r_state == S_IDLE) ? 8'hFF : seg7(r_level);
    end
  end

  assign genEnable   = r_gen_enable;
  assign clearCounts = r_clear_counts;
  assign postSig     = r_post_sig;
  assign level       = r_level;
  assign lives       = r_lives;
  assign gameOver    = r_game_over;
  assign gameWon     = r_game_won;
  assign timeSeg0    = r_time_seg0;
  assign timeSeg1    = r_time_seg1;
  assign levelSeg    = r_level_seg;
  assign dbgState    = r_state;

endmodule

// File: tb/tb_level_sequencer.sv
// Bench for level_sequencer: scenario tasks with inline checks against a game-rule model.
module tb_level_sequencer;

  localparam int PLAY_SECONDS = 3;
  localparam int NUM_LEVELS   = 2;
  localparam int START_LIVES  = 2;
  localparam int POST_TIMEOUT = 8;

  localparam logic [2:0] S_IDLE = 3'd0, S_PLAY = 3'd1, S_POST = 3'd2;
  localparam logic [2:0] S_JUDGE = 3'd3, S_WIN = 3'd4, S_OVER = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       level_complete = 1'b0;
  logic [7:0] magic = 8'd0;
  logic [7:0] user = 8'd0;

  logic       gen_enable, clear_counts, post_sig, game_over, game_won;
  logic [3:0] level;
  logic [2:0] lives, dbg_state;
  logic [7:0] time_seg0, time_seg1, level_seg;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] seg_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hD8, 8'h80, 8'h90};

  // Game model: 0 playing, 1 won, 2 over
  int exp_level, exp_lives, exp_end;

  level_sequencer #(
    .PLAY_SECONDS(PLAY_SECONDS), .NUM_LEVELS(NUM_LEVELS),
    .START_LIVES(START_LIVES), .POST_TIMEOUT(POST_TIMEOUT)
  ) dut (
    .Clk100M(clk), .Rst_n(rst_n), .tick1Hz(tick), .startBtn(start_btn),
    .levelComplete(level_complete), .magicSymbolCount(magic), .userCount(user),
    .genEnable(gen_enable), .clearCounts(clear_counts), .postSig(post_sig),
    .level(level), .lives(lives), .gameOver(game_over), .gameWon(game_won),
    .timeSeg0(time_seg0), .timeSeg1(time_seg1), .levelSeg(level_seg),
    .dbgState(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic model_restart();
    exp_level = 1; exp_lives = START_LIVES; exp_end = 0;
  endtask

  task automatic model_judge(input logic [7:0] u, input logic [7:0] m);
    if (u == m) begin
      if (exp_level == NUM_LEVELS) exp_end = 1;
      else exp_level++;
    end else if (exp_lives == 1) begin
      exp_lives = 0; exp_end = 2;
    end else begin
      exp_lives--;
    end
  endtask

  task automatic press_start(input logic with_tick);
    start_btn = 1'b1; tick = with_tick;
    @(posedge clk); #1;
    start_btn = 1'b0; tick = 1'b0;
    model_restart();
  endtask

  task automatic check_outcome(input string tag);
    logic [2:0] exp_state;
    exp_state = (exp_end == 1) ? S_WIN : (exp_end == 2) ? S_OVER : S_PLAY;
    checks++; if (dbg_state !== exp_state) begin errors++; $display("FAIL %s state got %0d exp %0d", tag, dbg_state, exp_state); end
    checks++; if (level !== 4'(exp_level)) begin errors++; $display("FAIL %s level got %0d exp %0d", tag, level, exp_level); end
    checks++; if (lives !== 3'(exp_lives)) begin errors++; $display("FAIL %s lives got %0d exp %0d", tag, lives, exp_lives); end
    checks++; if (game_won !== (exp_end == 1)) begin errors++; $display("FAIL %s gameWon got %b exp %b", tag, game_won, exp_end == 1); end
    checks++; if (game_over !== (exp_end == 2)) begin errors++; $display("FAIL %s gameOver got %b exp %b", tag, game_over, exp_end == 2); end
    checks++; if (gen_enable !== (exp_end == 0)) begin errors++; $display("FAIL %s genEnable got %b exp %b", tag, gen_enable, exp_end == 0); end
    checks++; if (clear_counts !== (exp_end == 0)) begin errors++; $display("FAIL %s clearCounts got %b exp %b", tag, clear_counts, exp_end == 0); end
  endtask

  // Called on the cycle right after PLAY was entered; ends in the first POST cycle + 1.
  task automatic run_play(input logic lc_spurious);
    checks++; if (dbg_state !== S_PLAY) begin errors++; $display("FAIL play_entry state got %0d exp %0d", dbg_state, S_PLAY); end
    checks++; if (clear_counts !== 1'b1) begin errors++; $display("FAIL play_entry clearCounts got %b exp 1", clear_counts); end
    checks++; if (gen_enable !== 1'b1) begin errors++; $display("FAIL play_entry genEnable got %b exp 1", gen_enable); end
    exp_q.delete();
    for (int k = PLAY_SECONDS; k >= 0; k--) exp_q.push_back(seg_tab[k % 10]);
    cyc(1);
    checks++; if (clear_counts !== 1'b0) begin errors++; $display("FAIL clear_pulse clearCounts got %b exp 0", clear_counts); end
    checks++; if (time_seg0 !== seg_tab[PLAY_SECONDS / 10]) begin errors++; $display("FAIL tens_digit got %h exp %h", time_seg0, seg_tab[PLAY_SECONDS / 10]); end
    checks++; if (time_seg1 !== exp_q[0]) begin errors++; $display("FAIL load_digit got %h exp %h", time_seg1, exp_q[0]); end
    void'(exp_q.pop_front());
    checks++; if (level_seg !== seg_tab[exp_level]) begin errors++; $display("FAIL level_seg got %h exp %h", level_seg, seg_tab[exp_level]); end
    if (lc_spurious) begin
      level_complete = 1'b1; cyc(1); level_complete = 1'b0; cyc(1);
      checks++; if (dbg_state !== S_PLAY) begin errors++; $display("FAIL lc_in_play state got %0d exp %0d", dbg_state, S_PLAY); end
      checks++; if (time_seg1 !== seg_tab[PLAY_SECONDS % 10]) begin errors++; $display("FAIL lc_in_play digit got %h exp %h", time_seg1, seg_tab[PLAY_SECONDS % 10]); end
    end
    for (int k = PLAY_SECONDS; k >= 1; k--) begin
      cyc($urandom_range(0, 3));
      do_tick();
      if (k > 1) begin
        checks++; if (gen_enable !== 1'b1 || post_sig !== 1'b0) begin errors++; $display("FAIL play_tick gen/post got %b%b exp 10", gen_enable, post_sig); end
      end else begin
        checks++; if (post_sig !== 1'b1) begin errors++; $display("FAIL post_sig got %b exp 1", post_sig); end
        checks++; if (gen_enable !== 1'b0) begin errors++; $display("FAIL gen_off_at_post got %b exp 0", gen_enable); end
        checks++; if (dbg_state !== S_POST) begin errors++; $display("FAIL post_entry state got %0d exp %0d", dbg_state, S_POST); end
      end
      cyc(1);
      if (k == 1) begin
        checks++; if (post_sig !== 1'b0) begin errors++; $display("FAIL post_sig_single got %b exp 0", post_sig); end
      end
      checks++; if (time_seg1 !== exp_q[0]) begin errors++; $display("FAIL countdown k=%0d got %h exp %h", k, time_seg1, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic judge_lc(input logic [7:0] u, input logic [7:0] m);
    user = u; magic = m;
    cyc($urandom_range(0, 2));
    checks++; if (dbg_state !== S_POST) begin errors++; $display("FAIL post_wait state got %0d exp %0d", dbg_state, S_POST); end
    level_complete = 1'b1;
    @(posedge clk); #1;
    level_complete = 1'b0;
    checks++; if (dbg_state !== S_JUDGE) begin errors++; $display("FAIL lc_judge state got %0d exp %0d", dbg_state, S_JUDGE); end
    model_judge(u, m);
    cyc(1);
    check_outcome("judge_lc");
  endtask

  task automatic judge_timeout(input logic [7:0] u, input logic [7:0] m, input logic coincide);
    user = u; magic = m;
    for (int t = 1; t <= POST_TIMEOUT; t++) begin
      cyc($urandom_range(0, 2));
      if (t == POST_TIMEOUT && coincide) level_complete = 1'b1;
      do_tick();
      level_complete = 1'b0;
      if (t < POST_TIMEOUT) begin
        checks++; if (dbg_state !== S_POST) begin errors++; $display("FAIL timeout_wait t=%0d state got %0d exp %0d", t, dbg_state, S_POST); end
      end else begin
        checks++; if (dbg_state !== S_JUDGE) begin errors++; $display("FAIL timeout_judge state got %0d exp %0d", dbg_state, S_JUDGE); end
      end
    end
    model_judge(u, m);
    cyc(1);
    check_outcome("judge_timeout");
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(2);
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, S_IDLE); end
    checks++; if (level !== 4'd1 || lives !== 3'(START_LIVES)) begin errors++; $display("FAIL reset_level_lives got %0d/%0d exp 1/%0d", level, lives, START_LIVES); end
    checks++; if ({gen_enable, clear_counts, post_sig, game_over, game_won} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {gen_enable, clear_counts, post_sig, game_over, game_won}); end
    checks++; if ({time_seg0, time_seg1, level_seg} !== 24'hFFFFFF) begin errors++; $display("FAIL reset_segs got %h exp ffffff", {time_seg0, time_seg1, level_seg}); end
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_idle_spurious();
    level_complete = 1'b1; tick = 1'b1;
    cyc(1);
    level_complete = 1'b0; tick = 1'b0;
    cyc(2);
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL idle_lc state got %0d exp %0d", dbg_state, S_IDLE); end
    checks++; if (gen_enable !== 1'b0 || post_sig !== 1'b0) begin errors++; $display("FAIL idle_lc gen/post got %b%b exp 00", gen_enable, post_sig); end
    checks++; if (time_seg1 !== 8'hFF || level_seg !== 8'hFF) begin errors++; $display("FAIL idle_segs got %h/%h exp ff/ff", time_seg1, level_seg); end
  endtask

  task automatic test_play_and_timeout();
    press_start(1'b1);
    run_play(1'b1);
    judge_timeout(8'd12, 8'd11, 1'b0);
  endtask

  task automatic test_pass_level();
    run_play(1'b0);
    judge_lc(8'd12, 8'd12);
    run_play(1'b0);
  endtask

  task automatic test_win();
    start_btn = 1'b1;
    judge_lc(8'd12, 8'd12);
    cyc(1);
    checks++; if (time_seg0 !== 8'hFF || time_seg1 !== 8'hFF) begin errors++; $display("FAIL win_segs got %h/%h exp ff/ff", time_seg0, time_seg1); end
    checks++; if (level_seg !== seg_tab[NUM_LEVELS]) begin errors++; $display("FAIL win_level_seg got %h exp %h", level_seg, seg_tab[NUM_LEVELS]); end
    cyc(5);
    checks++; if (dbg_state !== S_WIN || game_won !== 1'b1) begin errors++; $display("FAIL held_start state got %0d won %b exp %0d 1", dbg_state, game_won, S_WIN); end
    start_btn = 1'b0;
    cyc(2);
    checks++; if (dbg_state !== S_WIN) begin errors++; $display("FAIL release_start state got %0d exp %0d", dbg_state, S_WIN); end
    press_start(1'b0);
    check_outcome("win_restart");
  endtask

  task automatic test_game_over();
    run_play(1'b0);
    judge_lc(8'd12, 8'd11);
    run_play(1'b0);
    judge_timeout(8'd12, 8'd11, 1'b1);
    cyc(1);
    checks++; if (time_seg0 !== 8'hFF || time_seg1 !== 8'hFF) begin errors++; $display("FAIL over_segs got %h/%h exp ff/ff", time_seg0, time_seg1); end
    press_start(1'b0);
    check_outcome("over_restart");
  endtask

  task automatic test_random_game();
    logic [7:0] u, m;
    for (int r = 0; r < 12; r++) begin
      run_play(1'($urandom_range(0, 1)));
      u = 8'($urandom_range(0, 255));
      m = ($urandom_range(0, 1) == 1) ? u : (u ^ (8'd1 << $urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) judge_timeout(u, m, 1'($urandom_range(0, 1)));
      else judge_lc(u, m);
      if (exp_end != 0) begin
        cyc($urandom_range(1, 4));
        press_start(1'b0);
        check_outcome("random_restart");
      end
    end
  endtask

  task automatic test_async_reset();
    cyc(2);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL async_reset state got %0d exp %0d", dbg_state, S_IDLE); end
    checks++; if (gen_enable !== 1'b0 || clear_counts !== 1'b0) begin errors++; $display("FAIL async_reset gen/clear got %b%b exp 00", gen_enable, clear_counts); end
    checks++; if (level !== 4'd1 || lives !== 3'(START_LIVES)) begin errors++; $display("FAIL async_reset level/lives got %0d/%0d exp 1/%0d", level, lives, START_LIVES); end
    checks++; if ({time_seg0, time_seg1, level_seg} !== 24'hFFFFFF) begin errors++; $display("FAIL async_reset segs got %h exp ffffff", {time_seg0, time_seg1, level_seg}); end
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    model_restart();
    test_reset();
    test_idle_spurious();
    test_play_and_timeout();
    test_pass_level();
    test_win();
    test_game_over();
    test_random_game();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
Top-level game sequencer and initiator of the post-period handshake. It runs each level's timed symbol-generation phase and pulses postSig to start the post period. It then waits for the post period's levelComplete pulse and judges the player's count against magicSymbolCount. From the result it advances the level, deducts a life, or ends the game. It drives the level/time seven-segment digits while a level is being played.

Parameters:
PLAY_SECONDS, 20, length of each generation phase in 1 Hz ticks (1..99)
NUM_LEVELS, 9, level number that ends the game with a win on a correct answer (1..9)
START_LIVES, 3, lives loaded at game start (1..7)
POST_TIMEOUT, 8, ticks to wait in POST for levelComplete before forcing judgement

Ports:
Clk100M  in  1  system clock, all logic on rising edge
Rst_n  in  1  asynchronous active-low reset
tick1Hz  in  1  single-cycle enable, once per second, synchronous to Clk100M
startBtn  in  1  debounced start button, level-sensitive; only rising edges act
levelComplete  in  1  single-cycle pulse from post-period block
magicSymbolCount  in  8  true count of target symbols generated this level
userCount  in  8  player's entered count
genEnable  out  1  high while symbol generation runs
clearCounts  out  1  single-cycle pulse: zero symbol/user counters
postSig  out  1  single-cycle pulse: start post period
level  out  4  current level, 1..NUM_LEVELS
lives  out  3  remaining lives
gameOver  out  1  high in OVER state
gameWon  out  1  high in WIN state
timeSeg0  out  8  tens digit of remaining seconds, active-low segments
timeSeg1  out  8  ones digit of remaining seconds
levelSeg  out  8  level digit

Behaviour:
- Reset (async, Rst_n=0): state IDLE, level=1, lives=START_LIVES, remaining=0, postTimer=0. All pulse and flag outputs are 0. All seg outputs are 8'hFF (blank). startBtn edge register is cleared.
- Segment code, dp bit 7 off: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 D8, 8 80, 9 90, other FF.
- Start edge: startBtn=1 while the registered previous value is 0. Holding the button produces one event only.
- IDLE: on start edge -> PLAY. Load remaining=PLAY_SECONDS and pulse clearCounts in the transition cycle. A tick in the same cycle is ignored.
- PLAY: genEnable=1 and registered, so it rises the cycle after entry. Each tick decrements remaining. A tick with remaining==1 sets remaining=0 and moves to POST. postSig=1 for exactly the first POST cycle; genEnable=0 from that same cycle. postTimer=0.
- POST: genEnable=0. Each tick increments postTimer. levelComplete, or postTimer reaching POST_TIMEOUT, moves to JUDGE. If both occur in the same cycle, there is exactly one transition. levelComplete in any other state is ignored.
- JUDGE lasts 1 cycle:
  - userCount==magicSymbolCount (8-bit unsigned) and level==NUM_LEVELS -> WIN.
  - Equal and level<NUM_LEVELS -> level+1, PLAY, with reload and clearCounts as on IDLE exit.
  - Not equal and lives==1 -> lives=0, OVER.
  - Not equal and lives>1 -> lives-1, PLAY at the same level, with reload and clearCounts.
- WIN/OVER: gameWon or gameOver held high; genEnable=0. A start edge resets level=1 and lives=START_LIVES, clears the flag, and enters PLAY with reload and clearCounts.
- Display:
  - In PLAY, timeSeg0/1 show remaining/10 and remaining%10, updated the cycle after remaining changes.
  - In POST/JUDGE, both show 0.
  - In IDLE/WIN/OVER, both are FF.
  - levelSeg shows level in all states except IDLE, where it is FF.
- level never exceeds NUM_LEVELS. lives never underflows.
- Mid-operation reset returns to the IDLE values immediately, without waiting for a clock.

Test Plan:
- PLAY_SECONDS=3, start edge -> clearCounts 1 cycle, genEnable high, timeSeg1 C0-coded digits 3,2,1. On the 3rd tick, postSig is a single pulse and genEnable=0 in that cycle.
- Pass level: userCount=magicSymbolCount=12, levelComplete pulse in POST -> level 1->2 and PLAY reloaded to 3. levelSeg goes F9->A4.
- Failure to game over: START_LIVES=2, two wrong answers (12 vs 11) -> lives 2->1->0, gameOver=1, timeSegs FF. Start edge -> level=1, lives=2, PLAY.
- Win: NUM_LEVELS=2, two correct judgements -> gameWon=1, level stays 2, genEnable=0.
- Timeout and spurious inputs: no levelComplete for 8 ticks -> JUDGE after the 8th tick. levelComplete pulses in PLAY/IDLE cause no state change. levelComplete coincident with timeout -> single JUDGE.
- Edge cases: startBtn held high through WIN -> no restart until released and re-pressed. Rst_n low mid-PLAY -> outputs at reset values asynchronously.
